mat_op_seq: RTL and testbench

- Sequencer that runs one matrix operation on the shared matrix store.
- Launched by the top-level control FSM's start_op/op_sel; returns done_flag, error_flag and busy_flag to it.
- Reads operands A and B element by element from the matrix store, computes each result element, and writes it to the result buffer.
- One read outstanding at a time; writes use a ready handshake.

---
 rtl/mat_op_seq.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_mat_op_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_op_seq.sv
// Matrix operation sequencer: reads A/B elements from the matrix store one at a time,
// computes each result element and writes it to the result buffer with a ready handshake.
module mat_op_seq #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 20,
  parameter int MAX_DIM = 5,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_op,
  input  logic [2:0]        op_sel,
  input  logic [2:0]        a_rows,
  input  logic [2:0]        a_cols,
  input  logic [2:0]        b_rows,
  input  logic [2:0]        b_cols,
  input  logic [DATA_W-1:0] scalar,
  output logic              rd_req,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ACC_W-1:0]  wr_data,
  input  logic              wr_ready,
  output logic [2:0]        res_rows,
  output logic [2:0]        res_cols,
  output logic              busy_flag,
  output logic              done_flag,
  output logic              error_flag
);

  typedef enum logic [3:0] {
    IDLE, CHECK, RD_A, WAIT_A, RD_B, WAIT_B, CALC, WRITE, NEXT, DONE, ERR
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SCL = 3'd2;
  localparam logic [2:0] OP_TRN = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  function automatic logic [ADDR_W-1:0] rc_addr(input logic [2:0] r, input logic [2:0] c,
                                                 input logic [2:0] cols);
    return ADDR_W'(r) * ADDR_W'(cols) + ADDR_W'(c);
  endfunction

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (int'(d) <= MAX_DIM);
  endfunction

  function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Transpose walks A column-wise; mul walks A along row i, B along column j.
  function automatic logic [ADDR_W-1:0] a_addr_f(input logic [2:0] op, input logic [2:0] i,
                                                  input logic [2:0] j, input logic [2:0] k,
                                                  input logic [2:0] acols);
    case (op)
      OP_TRN:  return rc_addr(j, i, acols);
      OP_MUL:  return rc_addr(i, k, acols);
      default: return rc_addr(i, j, acols);
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] b_addr_f(input logic [2:0] op, input logic [2:0] i,
                                                  input logic [2:0] j, input logic [2:0] k,
                                                  input logic [2:0] bcols);
    case (op)
      OP_MUL:  return rc_addr(k, j, bcols);
      default: return rc_addr(i, j, bcols);
    endcase
  endfunction

  state_t              state_r;
  logic [2:0]          op_r, a_rows_r, a_cols_r, b_rows_r, b_cols_r;
  logic [DATA_W-1:0]   scalar_r, a_val_r, b_val_r;
  logic [2:0]          i_r, j_r, k_r;
  logic [ACC_W-1:0]    acc_r;
  logic                last_r;

  logic                check_ok_s, needs_b_s, last_s, k_last_s;
  logic [2:0]          res_rows_s, res_cols_s;
  logic [ACC_W-1:0]    a_ext_s, b_ext_s, s_ext_s, acc_base_s, calc_s;

  // Operand legality and result shape for the latched operation.
  always_comb begin
    check_ok_s = 1'b0;
    res_rows_s = a_rows_r;
    res_cols_s = a_cols_r;
    needs_b_s  = 1'b0;
    case (op_r)
      OP_ADD, OP_SUB: begin
        check_ok_s = dim_ok(a_rows_r) && dim_ok(a_cols_r) && dim_ok(b_rows_r) && dim_ok(b_cols_r)
                     && (a_rows_r == b_rows_r) && (a_cols_r == b_cols_r);
        needs_b_s  = 1'b1;
      end
      OP_SCL: check_ok_s = dim_ok(a_rows_r) && dim_ok(a_cols_r);
      OP_TRN: begin
        check_ok_s = dim_ok(a_rows_r) && dim_ok(a_cols_r);
        res_rows_s = a_cols_r;
        res_cols_s = a_rows_r;
      end
      OP_MUL: begin
        check_ok_s = dim_ok(a_rows_r) && dim_ok(a_cols_r) && dim_ok(b_rows_r) && dim_ok(b_cols_r)
                     && (a_cols_r == b_rows_r);
        res_cols_s = b_cols_r;
        needs_b_s  = 1'b1;
      end
      default: check_ok_s = 1'b0;
    endcase
  end

  // Element arithmetic; everything wraps modulo 2^ACC_W.
  always_comb begin
    a_ext_s    = sext(a_val_r);
    b_ext_s    = sext(b_val_r);
    s_ext_s    = sext(scalar_r);
    if (k_r == 3'd0) begin
      acc_base_s = {ACC_W{1'b0}};
    end else begin
      acc_base_s = acc_r;
    end
    case (op_r)
      OP_ADD:  calc_s = a_ext_s + b_ext_s;
      OP_SUB:  calc_s = a_ext_s - b_ext_s;
      OP_SCL:  calc_s = a_ext_s * s_ext_s;
      OP_TRN:  calc_s = a_ext_s;
      OP_MUL:  calc_s = acc_base_s + a_ext_s * b_ext_s;
      default: calc_s = a_ext_s;
    endcase
  end

  // Loop-end detection for the element and inner-product counters.
  always_comb begin
    last_s   = (i_r == res_rows - 3'd1) && (j_r == res_cols - 3'd1);
    k_last_s = (k_r == a_cols_r - 3'd1);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      op_r       <= 3'd0;
      a_rows_r   <= 3'd0;
      a_cols_r   <= 3'd0;
      b_rows_r   <= 3'd0;
      b_cols_r   <= 3'd0;
      scalar_r   <= {DATA_W{1'b0}};
      a_val_r    <= {DATA_W{1'b0}};
      b_val_r    <= {DATA_W{1'b0}};
      i_r        <= 3'd0;
      j_r        <= 3'd0;
      k_r        <= 3'd0;
      acc_r      <= {ACC_W{1'b0}};
      last_r     <= 1'b0;
      rd_req     <= 1'b0;
      rd_sel     <= 1'b0;
      rd_addr    <= {ADDR_W{1'b0}};
      wr_en      <= 1'b0;
      wr_addr    <= {ADDR_W{1'b0}};
      wr_data    <= {ACC_W{1'b0}};
      res_rows   <= 3'd0;
      res_cols   <= 3'd0;
      busy_flag  <= 1'b0;
      done_flag  <= 1'b0;
      error_flag <= 1'b0;
    end else begin
      rd_req     <= 1'b0;
      done_flag  <= 1'b0;
      error_flag <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_op) begin
            op_r      <= op_sel;
            a_rows_r  <= a_rows;
            a_cols_r  <= a_cols;
            b_rows_r  <= b_rows;
            b_cols_r  <= b_cols;
            scalar_r  <= scalar;
            busy_flag <= 1'b1;
            state_r   <= CHECK;
          end
        end
        CHECK: begin
          rd_sel <= 1'b0;
          if (check_ok_s) begin
            res_rows <= res_rows_s;
            res_cols <= res_cols_s;
            i_r      <= 3'd0;
            j_r      <= 3'd0;
            k_r      <= 3'd0;
            rd_req   <= 1'b1;
            rd_addr  <= a_addr_f(op_r, 3'd0, 3'd0, 3'd0, a_cols_r);
            state_r  <= RD_A;
          end else begin
            res_rows   <= 3'd0;
            res_cols   <= 3'd0;
            error_flag <= 1'b1;
            state_r    <= ERR;
          end
        end
        RD_A: state_r <= WAIT_A;
        WAIT_A: begin
          if (rd_valid) begin
            a_val_r <= rd_data;
            if (needs_b_s) begin
              rd_req  <= 1'b1;
              rd_sel  <= 1'b1;
              rd_addr <= b_addr_f(op_r, i_r, j_r, k_r, b_cols_r);
              state_r <= RD_B;
            end else begin
              state_r <= CALC;
            end
          end
        end
        RD_B: state_r <= WAIT_B;
        WAIT_B: begin
          if (rd_valid) begin
            b_val_r <= rd_data;
            state_r <= CALC;
          end
        end
        CALC: begin
          acc_r <= calc_s;
          if ((op_r == OP_MUL) && !k_last_s) begin
            k_r     <= k_r + 3'd1;
            rd_req  <= 1'b1;
            rd_sel  <= 1'b0;
            rd_addr <= a_addr_f(op_r, i_r, j_r, k_r + 3'd1, a_cols_r);
            state_r <= RD_A;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= rc_addr(i_r, j_r, res_cols);
            wr_data <= calc_s;
            state_r <= WRITE;
          end
        end
        WRITE: begin
          // Counters advance on acceptance so NEXT already sees the new (i,j).
          if (wr_ready) begin
            wr_en  <= 1'b0;
            last_r <= last_s;
            k_r    <= 3'd0;
            if (j_r == res_cols - 3'd1) begin
              j_r <= 3'd0;
              i_r <= i_r + 3'd1;
            end else begin
              j_r <= j_r + 3'd1;
            end
            state_r <= NEXT;
          end
        end
        NEXT: begin
          if (last_r) begin
            done_flag <= 1'b1;
            state_r   <= DONE;
          end else begin
            rd_req  <= 1'b1;
            rd_sel  <= 1'b0;
            rd_addr <= a_addr_f(op_r, i_r, j_r, 3'd0, a_cols_r);
            state_r <= RD_A;
          end
        end
        DONE: begin
          busy_flag <= 1'b0;
          state_r   <= IDLE;
        end
        ERR: begin
          busy_flag <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          busy_flag <= 1'b0;
          wr_en     <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_op_seq.sv
// Scoreboard bench for mat_op_seq: directed operations push expected writes, a monitor
// pops and compares each accepted write; a memory model answers reads with optional delay.
module tb_mat_op_seq;

  logic        clk = 1'b0;
  logic        rst, start_op;
  logic [2:0]  op_sel, a_rows, a_cols, b_rows, b_cols;
  logic [7:0]  scalar;
  logic        rd_req, rd_sel, rd_valid, wr_en, wr_ready;
  logic [4:0]  rd_addr, wr_addr;
  logic [7:0]  rd_data;
  logic [19:0] wr_data;
  logic [2:0]  res_rows, res_cols;
  logic        busy_flag, done_flag, error_flag;

  mat_op_seq dut (
    .clk(clk), .rst(rst), .start_op(start_op), .op_sel(op_sel),
    .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols), .scalar(scalar),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .res_rows(res_rows), .res_cols(res_cols),
    .busy_flag(busy_flag), .done_flag(done_flag), .error_flag(error_flag)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];

  int checks = 0, fails = 0;
  int mem_a[32], mem_b[32];
  int a_reads = 0, b_reads = 0, done_cnt = 0, err_cnt = 0, busy_cycles = 0;
  int rd_delay = 0, wr_stall = 0;
  bit rd_pend = 1'b0, rd_psel;
  int rd_wait, rd_paddr;
  bit held_v = 1'b0;
  int held_addr, held_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int a, input int d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic load6(input bit sel, input int v0, v1, v2, v3, v4, v5);
    int v[6];
    v = '{v0, v1, v2, v3, v4, v5};
    for (int n = 0; n < 6; n++) begin
      if (sel) mem_b[n] = v[n];
      else     mem_a[n] = v[n];
    end
  endtask

  // Read responder: rd_valid arrives rd_delay cycles after the minimum.
  always @(negedge clk) begin
    rd_valid = 1'b0;
    if (rd_pend) begin
      if (rd_wait == 0) begin
        rd_valid = 1'b1;
        rd_data  = 8'(rd_psel ? mem_b[rd_paddr] : mem_a[rd_paddr]);
        rd_pend  = 1'b0;
      end else begin
        rd_wait--;
      end
    end
    if (rd_req) begin
      chk("one_read_outstanding", int'(rd_pend), 0);
      rd_pend  = 1'b1;
      rd_wait  = rd_delay;
      rd_paddr = int'(rd_addr);
      rd_psel  = rd_sel;
      if (rd_sel) b_reads++;
      else        a_reads++;
    end
  end

  // Write acceptor with an optional stall on the next write.
  always @(posedge clk) begin
    #1;
    if (wr_stall > 0 && wr_en) begin
      wr_ready = 1'b0;
      wr_stall--;
    end else begin
      wr_ready = 1'b1;
    end
  end

  // Monitor: scoreboard pops on accepted writes, stability while stalled, flag pulses.
  always @(negedge clk) begin
    if (busy_flag) busy_cycles++;
    if (wr_en) begin
      if (held_v) begin
        chk("wr_addr_stable", int'(wr_addr), held_addr);
        chk("wr_data_stable", int'($signed(wr_data)), held_data);
      end
      if (wr_ready) begin
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", int'(wr_addr), e.addr);
          chk("wr_data", int'($signed(wr_data)), e.data);
        end
      end else begin
        held_v    = 1'b1;
        held_addr = int'(wr_addr);
        held_data = int'($signed(wr_data));
      end
    end else begin
      held_v = 1'b0;
    end
    if (done_flag) begin
      done_cnt++;
      chk("all_writes_before_done", exp_q.size(), 0);
    end
    if (error_flag) err_cnt++;
  end

  task automatic launch(input logic [2:0] op, input int ar, ac, br, bc, sc);
    @(posedge clk); #1;
    start_op = 1'b1;
    op_sel   = op;
    a_rows   = 3'(ar);
    a_cols   = 3'(ac);
    b_rows   = 3'(br);
    b_cols   = 3'(bc);
    scalar   = 8'(sc);
    @(posedge clk); #1;
    start_op = 1'b0;
    op_sel   = 3'b111;
    a_rows   = 3'd7;
    a_cols   = 3'd7;
    b_rows   = 3'd7;
    b_cols   = 3'd7;
    scalar   = 8'd0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!done_flag && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, int'(done_flag), 1);
    @(negedge clk);
    chk({name, "_idle_after"}, int'({busy_flag, done_flag}), 0);
  endtask

  task automatic err_test(input string name, input logic [2:0] op, input int ar, ac, br, bc);
    int r0, e0;
    r0 = a_reads + b_reads;
    e0 = err_cnt;
    launch(op, ar, ac, br, bc, 0);
    @(negedge clk);
    chk({name, "_check_cycle"}, int'({busy_flag, error_flag}), 2);
    @(negedge clk);
    chk({name, "_error_flag"}, int'(error_flag), 1);
    chk({name, "_res_dims"}, int'({res_rows, res_cols}), 0);
    @(negedge clk);
    chk({name, "_pulse_end"}, int'({busy_flag, error_flag}), 0);
    chk({name, "_no_reads"}, a_reads + b_reads, r0);
    chk({name, "_err_count"}, err_cnt - e0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found, e0;
    rst = 1'b1; start_op = 1'b0; op_sel = 3'd0; scalar = 8'd0; wr_ready = 1'b1;
    a_rows = 3'd0; a_cols = 3'd0; b_rows = 3'd0; b_cols = 3'd0;
    rd_valid = 1'b0; rd_data = 8'd0;
    foreach (mem_a[n]) begin mem_a[n] = 0; mem_b[n] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", int'({rd_req, rd_sel, wr_en, busy_flag, done_flag, error_flag,
                            res_rows, res_cols}), 0);
    chk("reset_data", int'({rd_addr, wr_addr, wr_data}), 0);
    @(posedge clk); #1 rst = 1'b0;

    // add 2x2
    load6(1'b0, 1, 2, 3, 4, 0, 0);
    load6(1'b1, 5, 6, 7, -8, 0, 0);
    push_exp(0, 6); push_exp(1, 8); push_exp(2, 10); push_exp(3, -4);
    busy_cycles = 0;
    launch(3'd0, 2, 2, 2, 2, 0);
    wait_done("add", 200);
    chk("add_busy_cycles", busy_cycles, 30);
    chk("add_res_dims", int'({res_rows, res_cols}), int'({3'd2, 3'd2}));

    // sub 2x2, same operands
    push_exp(0, -4); push_exp(1, -4); push_exp(2, -4); push_exp(3, 12);
    launch(3'd1, 2, 2, 2, 2, 0);
    wait_done("sub", 200);

    // mul 2x3 * 3x2
    load6(1'b0, 1, 2, 3, 4, 5, 6);
    load6(1'b1, 7, 8, 9, 10, 11, 12);
    push_exp(0, 58); push_exp(1, 64); push_exp(2, 139); push_exp(3, 154);
    a_reads = 0; b_reads = 0;
    launch(3'd4, 2, 3, 3, 2, 0);
    wait_done("mul", 400);
    chk("mul_a_reads", a_reads, 12);
    chk("mul_b_reads", b_reads, 12);

    // transpose 2x3
    push_exp(0, 1); push_exp(1, 4); push_exp(2, 2); push_exp(3, 5); push_exp(4, 3); push_exp(5, 6);
    a_reads = 0; b_reads = 0;
    launch(3'd3, 2, 3, 0, 0, 0);
    wait_done("trn", 300);
    chk("trn_res_rows", int'(res_rows), 3);
    chk("trn_res_cols", int'(res_cols), 2);
    chk("trn_a_reads", a_reads, 6);
    chk("trn_b_reads", b_reads, 0);

    // rejected operations
    err_test("err_dim_mismatch", 3'd0, 2, 2, 2, 3);
    err_test("err_bad_op", 3'b101, 2, 2, 2, 2);
    err_test("err_zero_rows", 3'd2, 0, 2, 0, 0);

    // scalar with read and write stalls
    load6(1'b0, 5, -7, 127, -128, 0, 0);
    push_exp(0, -15); push_exp(1, 21); push_exp(2, -381); push_exp(3, 384);
    rd_delay = 3; wr_stall = 4; busy_cycles = 0;
    launch(3'd2, 2, 2, 0, 0, -3);
    wait_done("scl_stall", 400);
    chk("scl_busy_cycles", busy_cycles, 38);
    rd_delay = 0; wr_stall = 0;

    // start_op while busy is ignored
    load6(1'b0, 1, 2, 3, 4, 0, 0);
    load6(1'b1, 5, 6, 7, -8, 0, 0);
    push_exp(0, 6); push_exp(1, 8); push_exp(2, 10); push_exp(3, -4);
    e0 = err_cnt;
    launch(3'd0, 2, 2, 2, 2, 0);
    repeat (4) @(posedge clk);
    #1;
    start_op = 1'b1; op_sel = 3'b101; a_rows = 3'd0;
    @(posedge clk); #1 start_op = 1'b0;
    wait_done("busy_retrigger", 200);
    chk("busy_retrigger_no_error", err_cnt - e0, 0);

    // reset during WAIT_B of a mul
    load6(1'b0, 1, 2, 3, 4, 5, 6);
    load6(1'b1, 7, 8, 9, 10, 11, 12);
    e0 = done_cnt;
    launch(3'd4, 2, 3, 3, 2, 0);
    found = 0;
    for (int n = 0; n < 50 && found == 0; n++) begin
      @(negedge clk);
      if (rd_req && rd_sel) found = 1;
    end
    chk("rst_reached_b_read", found, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midop_reset_ctrl", int'({rd_req, rd_sel, wr_en, busy_flag, done_flag, error_flag,
                                  res_rows, res_cols}), 0);
    chk("midop_reset_data", int'({rd_addr, wr_addr, wr_data}), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midop_reset_no_done", done_cnt - e0, 0);
    chk("midop_reset_stays_idle", int'({busy_flag, wr_en, rd_req}), 0);

    // fresh launch after reset
    load6(1'b0, 1, 2, 3, 4, 0, 0);
    load6(1'b1, 5, 6, 7, -8, 0, 0);
    push_exp(0, 6); push_exp(1, 8); push_exp(2, 10); push_exp(3, -4);
    launch(3'd0, 2, 2, 2, 2, 0);
    wait_done("after_reset", 200);
    chk("after_reset_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
